// File: rtl/ir_fetch_sequencer_pkg.sv
// Shared widths, fetch-state encoding and helpers for the IR fetch sequencer.
package ir_fetch_sequencer_pkg;

  localparam int unsigned DATA_WIDTH    = 8;
  localparam int unsigned IR_ADDR_WIDTH = 8;
  localparam int unsigned STATE_WIDTH   = 3;
  localparam int unsigned BUNDLE_BYTES  = 4;

  localparam logic [DATA_WIDTH-1:0] HALT_OP_DEFAULT = 8'hFF;

  typedef enum logic [STATE_WIDTH-1:0] {
    FS_IDLE  = 3'd0,
    FS_F_OP  = 3'd1,
    FS_F_P0  = 3'd2,
    FS_F_P1  = 3'd3,
    FS_F_P2  = 3'd4,
    FS_ISSUE = 3'd5,
    FS_HALT  = 3'd6
  } fetch_state_e;

  // True for the four states that own a cache read.
  function automatic logic is_fetch_state(input fetch_state_e s);
    return (s == FS_F_OP) || (s == FS_F_P0) || (s == FS_F_P1) || (s == FS_F_P2);
  endfunction

endpackage

// File: rtl/ir_fetch_sequencer.sv
// Fetches 4-byte instruction bundles from the cache read port and hands them
// to the IR decoder; follows decoder jumps and parks on the HALT opcode.
module ir_fetch_sequencer
  import ir_fetch_sequencer_pkg::*;
#(
  parameter int unsigned    DW       = DATA_WIDTH,
  parameter int unsigned    AW       = IR_ADDR_WIDTH,
  parameter logic [DW-1:0]  HALT_OP  = DW'(HALT_OP_DEFAULT),
  parameter logic [AW-1:0]  START_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cash_init_load_finished,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_rd_valid,
  input  logic [DW-1:0] mem_rd_data,
  output logic          ir_valid,
  input  logic          ir_ready,
  output logic [DW-1:0] ir_op,
  output logic [DW-1:0] ir_p0,
  output logic [DW-1:0] ir_p1,
  output logic [DW-1:0] ir_p2,
  output logic [AW-1:0] irp,
  input  logic          jump_valid,
  input  logic [AW-1:0] jump_addr,
  input  logic          restart,
  output logic          halted
);

  fetch_state_e  state, state_nxt;
  logic [AW-1:0] pc, pc_nxt;
  logic [AW-1:0] irp_nxt;
  logic [AW-1:0] mem_addr_nxt;
  logic          mem_rd_en_nxt;
  logic          ir_valid_nxt;
  logic          halted_nxt;
  logic [DW-1:0] op_nxt, p0_nxt, p1_nxt, p2_nxt;
  logic          outstanding, outstanding_nxt;
  logic          discard, discard_nxt;
  logic          req_sent, req_sent_nxt;

  logic          jump_c;
  logic          rd_ret_c;
  logic          out_keep_c;
  logic          take_c;
  logic          fresh_c;
  logic          pend_c;
  logic          issue_c;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    irp_nxt         = irp;
    op_nxt          = ir_op;
    p0_nxt          = ir_p0;
    p1_nxt          = ir_p1;
    p2_nxt          = ir_p2;
    mem_addr_nxt    = mem_addr;
    mem_rd_en_nxt   = 1'b0;
    ir_valid_nxt    = 1'b0;
    halted_nxt      = 1'b0;
    outstanding_nxt = 1'b0;
    discard_nxt     = 1'b0;
    req_sent_nxt    = 1'b0;

    // Redirects only matter once fetching has started and before HALT.
    jump_c     = jump_valid && (state != FS_IDLE) && (state != FS_HALT);
    // Returns with nothing outstanding are stray and ignored.
    rd_ret_c   = outstanding && mem_rd_valid;
    out_keep_c = outstanding && !mem_rd_valid;
    // A jump in the same cycle as a return drops the returned byte.
    take_c     = rd_ret_c && !discard && !jump_c;

    case (state)
      FS_IDLE: begin
        if (cash_init_load_finished) state_nxt = FS_F_OP;
      end
      FS_F_OP: begin
        if (take_c) begin
          op_nxt    = mem_rd_data;
          pc_nxt    = pc + AW'(1);
          state_nxt = FS_F_P0;
        end
      end
      FS_F_P0: begin
        if (take_c) begin
          p0_nxt    = mem_rd_data;
          pc_nxt    = pc + AW'(1);
          state_nxt = FS_F_P1;
        end
      end
      FS_F_P1: begin
        if (take_c) begin
          p1_nxt    = mem_rd_data;
          pc_nxt    = pc + AW'(1);
          state_nxt = FS_F_P2;
        end
      end
      FS_F_P2: begin
        if (take_c) begin
          p2_nxt    = mem_rd_data;
          pc_nxt    = pc + AW'(1);
          state_nxt = FS_ISSUE;
        end
      end
      FS_ISSUE: begin
        // ir_valid is high for the whole ISSUE state, so ready alone completes it.
        if (ir_ready) begin
          irp_nxt   = pc;
          state_nxt = (ir_op == HALT_OP) ? FS_HALT : FS_F_OP;
        end
      end
      FS_HALT: begin
        if (restart) begin
          pc_nxt    = START_PC;
          irp_nxt   = START_PC;
          state_nxt = FS_F_OP;
        end
      end
      default: state_nxt = FS_IDLE;
    endcase

    // Jump overrides everything, including a coincident HALT issue.
    if (jump_c) begin
      pc_nxt    = jump_addr;
      irp_nxt   = jump_addr;
      state_nxt = FS_F_OP;
    end

    // A new fetch step needs one request; it waits while an old read is in flight.
    fresh_c = (state_nxt != state) || jump_c;
    pend_c  = fresh_c || !req_sent;
    issue_c = is_fetch_state(state_nxt) && pend_c && !out_keep_c;

    req_sent_nxt    = is_fetch_state(state_nxt) && (!pend_c || issue_c);
    outstanding_nxt = out_keep_c || issue_c;
    discard_nxt     = out_keep_c && (discard || jump_c);

    mem_rd_en_nxt = issue_c;
    if (issue_c) mem_addr_nxt = pc_nxt;

    ir_valid_nxt = (state_nxt == FS_ISSUE);
    halted_nxt   = (state_nxt == FS_HALT);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FS_IDLE;
      pc          <= START_PC;
      irp         <= START_PC;
      mem_rd_en   <= 1'b0;
      mem_addr    <= '0;
      ir_valid    <= 1'b0;
      ir_op       <= '0;
      ir_p0       <= '0;
      ir_p1       <= '0;
      ir_p2       <= '0;
      halted      <= 1'b0;
      outstanding <= 1'b0;
      discard     <= 1'b0;
      req_sent    <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      irp         <= irp_nxt;
      mem_rd_en   <= mem_rd_en_nxt;
      mem_addr    <= mem_addr_nxt;
      ir_valid    <= ir_valid_nxt;
      ir_op       <= op_nxt;
      ir_p0       <= p0_nxt;
      ir_p1       <= p1_nxt;
      ir_p2       <= p2_nxt;
      halted      <= halted_nxt;
      outstanding <= outstanding_nxt;
      discard     <= discard_nxt;
      req_sent    <= req_sent_nxt;
    end
  end

endmodule

// File: tb/tb_ir_fetch_sequencer.sv
// Bench for ir_fetch_sequencer: cache model, transaction-level reference model
// checked every cycle, and directed scenarios with literal expectations.
module tb_ir_fetch_sequencer;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 8;
  localparam logic [7:0] HALT  = 8'hFF;
  localparam logic [7:0] START = 8'h00;

  logic          clk;
  logic          rst_n;
  logic          cash_init_load_finished;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic          mem_rd_valid;
  logic [DW-1:0] mem_rd_data;
  logic          ir_valid;
  logic          ir_ready;
  logic [DW-1:0] ir_op, ir_p0, ir_p1, ir_p2;
  logic [AW-1:0] irp;
  logic          jump_valid;
  logic [AW-1:0] jump_addr;
  logic          restart;
  logic          halted;

  ir_fetch_sequencer #(.DW(DW), .AW(AW), .HALT_OP(HALT), .START_PC(START)) dut (
    .clk(clk), .rst_n(rst_n), .cash_init_load_finished(cash_init_load_finished),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_valid(mem_rd_valid),
    .mem_rd_data(mem_rd_data), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .ir_op(ir_op), .ir_p0(ir_p0), .ir_p1(ir_p1), .ir_p2(ir_p2), .irp(irp),
    .jump_valid(jump_valid), .jump_addr(jump_addr), .restart(restart), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Cache: answers each request after 'lat' cycles; keeps counting through reset.
  logic [7:0] mem [256];
  int         lat = 1;
  int         c_cnt = 0;
  logic [7:0] c_addr = '0;

  always @(negedge clk) begin
    mem_rd_valid = 1'b0;
    if (c_cnt > 0) begin
      c_cnt--;
      if (c_cnt == 0) begin
        mem_rd_valid = 1'b1;
        mem_rd_data  = mem[c_addr];
      end
    end
    if (mem_rd_en) begin
      c_cnt  = lat;
      c_addr = mem_addr;
    end
  end

  // Reference model: next read address, bytes gathered so far, pointer and halt flag.
  logic [7:0] m_pc, m_irp;
  logic [2:0] m_phase;
  logic [7:0] m_bundle [4];
  bit         m_pending, m_drop, m_halted, m_run, p_ir_valid;
  logic [7:0] rd_log [$];

  always @(posedge clk) begin
    bit jmp, hs, ok;
    #1;
    if (!rst_n) begin
      m_pc = START; m_irp = START; m_phase = 3'd0;
      m_pending = 0; m_drop = 0; m_halted = 0; m_run = 0; p_ir_valid = 0;
      chk("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
      chk("rst_mem_addr",  32'(mem_addr),  32'd0);
      chk("rst_ir_valid",  32'(ir_valid),  32'd0);
      chk("rst_ir_op",     32'(ir_op),     32'd0);
      chk("rst_halted",    32'(halted),    32'd0);
      chk("rst_irp",       32'(irp),       32'(START));
    end else begin
      jmp = jump_valid && m_run && !m_halted;
      hs  = p_ir_valid && ir_ready;
      if (m_halted) begin
        if (restart) begin
          m_halted = 0; m_pc = START; m_irp = START; m_phase = 3'd0;
        end
      end else begin
        if (mem_rd_valid && m_pending) begin
          m_pending = 0;
          if (m_drop) m_drop = 0;
          else if (!jmp && m_phase < 3'd4) begin
            m_bundle[m_phase[1:0]] = mem_rd_data;
            m_phase = m_phase + 3'd1;
            m_pc    = m_pc + 8'd1;
          end
        end
        if (hs) begin
          m_irp   = m_pc;
          m_phase = 3'd0;
          if (m_bundle[0] == HALT && !jmp) m_halted = 1;
        end
        if (jmp) begin
          m_pc = jump_addr; m_irp = jump_addr; m_phase = 3'd0;
          if (m_pending) m_drop = 1;
        end
      end
      if (!m_run && cash_init_load_finished) m_run = 1;

      if (mem_rd_en) begin
        ok = m_run && !m_halted && !m_pending && (m_phase < 3'd4);
        chk("model_rd_allowed", 32'(ok), 32'd1);
        chk("model_rd_addr", 32'(mem_addr), 32'(m_pc));
        m_pending = 1;
        rd_log.push_back(mem_addr);
      end
      chk("model_ir_valid", 32'(ir_valid), 32'(m_phase == 3'd4));
      if (ir_valid && m_phase == 3'd4)
        chk("model_bundle", {ir_op, ir_p0, ir_p1, ir_p2},
            {m_bundle[0], m_bundle[1], m_bundle[2], m_bundle[3]});
      chk("model_irp", 32'(irp), 32'(m_irp));
      chk("model_halted", 32'(halted), 32'(m_halted));
      p_ir_valid = ir_valid;
    end
  end

  // Waits (sampling on the falling edge) for ir_valid or a read request.
  task automatic wait_for(input string name, input bit want_valid, input int want_addr,
                          input int budget, output int cyc);
    bit hit;
    cyc = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (want_valid) hit = ir_valid;
      else            hit = mem_rd_en && (want_addr < 0 || int'(mem_addr) == want_addr);
      if (hit) begin
        cyc = i;
        break;
      end
    end
    chk({name, "_seen"}, 32'(cyc != 0), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst_n = 1'b0; cash_init_load_finished = 1'b0; ir_ready = 1'b0;
    jump_valid = 1'b0; jump_addr = '0; restart = 1'b0;
    mem_rd_valid = 1'b0; mem_rd_data = '0;
    for (int i = 0; i < 256; i++) mem[i] = {1'b0, i[6:0]};
    mem[8'h00] = 8'h01; mem[8'h01] = 8'h02; mem[8'h02] = 8'h03; mem[8'h03] = 8'h04;
    mem[8'h04] = 8'h11;
    mem[8'h40] = 8'h21; mem[8'h41] = 8'h22; mem[8'h42] = 8'h23; mem[8'h43] = 8'h24;
    mem[8'hFE] = 8'hAA; mem[8'hFF] = 8'hBB;
    mem[8'h80] = 8'hFF; mem[8'h81] = 8'h01; mem[8'h82] = 8'h02; mem[8'h83] = 8'h03;

    // Reset and idle until the cache preload is reported complete.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("idle_no_read", 32'(mem_rd_en), 32'd0);

    // First bundle: reads 0..3, 8 cycles from the first request to ir_valid.
    rd_log.delete();
    cash_init_load_finished = 1'b1;
    wait_for("t1_first_rd", 1'b0, -1, 10, cyc);
    chk("t1_first_rd_delay", 32'(cyc), 32'd1);
    chk("t1_first_rd_addr", 32'(mem_addr), 32'h00);
    wait_for("t1_ir_valid", 1'b1, -1, 30, cyc);
    chk("t1_latency", 32'(cyc), 32'd8);
    chk("t1_bundle", {ir_op, ir_p0, ir_p1, ir_p2}, 32'h01020304);
    chk("t1_rd_count", 32'(rd_log.size()), 32'd4);
    if (rd_log.size() == 4)
      chk("t1_rd_addrs", {rd_log[0], rd_log[1], rd_log[2], rd_log[3]}, 32'h00010203);

    // Decoder stalls: bundle held, no reads; then accepted and fetch moves to 4.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_hold_valid", 32'(ir_valid), 32'd1);
      chk("t2_hold_op", 32'(ir_op), 32'h01);
      chk("t2_hold_p2", 32'(ir_p2), 32'h04);
      chk("t2_hold_no_rd", 32'(mem_rd_en), 32'd0);
    end
    @(posedge clk);
    lat = 3;
    @(negedge clk);
    ir_ready = 1'b1;
    @(negedge clk);
    chk("t2_accept_valid", 32'(ir_valid), 32'd0);
    chk("t2_accept_irp", 32'(irp), 32'h04);
    chk("t2_next_rd_en", 32'(mem_rd_en), 32'd1);
    chk("t2_next_rd_addr", 32'(mem_addr), 32'h04);

    // Jump while the F_P1 read is in flight on a 3-cycle cache.
    wait_for("t3_p1_rd", 1'b0, 6, 40, cyc);
    jump_valid = 1'b1; jump_addr = 8'h40;
    @(negedge clk);
    jump_valid = 1'b0;
    chk("t3_irp", 32'(irp), 32'h40);
    chk("t3_no_rd", 32'(mem_rd_en), 32'd0);
    wait_for("t3_redirect_rd", 1'b0, -1, 20, cyc);
    chk("t3_redirect_delay", 32'(cyc), 32'd3);
    chk("t3_redirect_addr", 32'(mem_addr), 32'h40);
    wait_for("t3_ir_valid", 1'b1, -1, 40, cyc);
    chk("t3_bundle", {ir_op, ir_p0, ir_p1, ir_p2}, 32'h21222324);
    @(negedge clk);
    chk("t3_irp_after", 32'(irp), 32'h44);

    // Bundle straddling the address wrap.
    mem[8'h00] = 8'hCC; mem[8'h01] = 8'hDD;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    rd_log.delete();
    jump_valid = 1'b1; jump_addr = 8'hFE;
    @(negedge clk);
    jump_valid = 1'b0;
    wait_for("t4_ir_valid", 1'b1, -1, 40, cyc);
    chk("t4_bundle", {ir_op, ir_p0, ir_p1, ir_p2}, 32'hAABBCCDD);
    chk("t4_rd_count", 32'(rd_log.size()), 32'd4);
    if (rd_log.size() == 4)
      chk("t4_rd_addrs", {rd_log[0], rd_log[1], rd_log[2], rd_log[3]}, 32'hFEFF0001);
    @(negedge clk);
    chk("t4_irp_wrap", 32'(irp), 32'h02);

    // HALT opcode cancelled by a jump coincident with its acceptance.
    ir_ready = 1'b0;
    jump_valid = 1'b1; jump_addr = 8'h80;
    @(negedge clk);
    jump_valid = 1'b0;
    wait_for("t5b_ir_valid", 1'b1, -1, 40, cyc);
    chk("t5b_halt_op", 32'(ir_op), 32'hFF);
    ir_ready = 1'b1; jump_valid = 1'b1; jump_addr = 8'h20;
    @(negedge clk);
    jump_valid = 1'b0;
    chk("t5b_not_halted", 32'(halted), 32'd0);
    chk("t5b_irp", 32'(irp), 32'h20);
    chk("t5b_rd_addr", 32'(mem_rd_en ? mem_addr : 8'h00), 32'h20);

    // HALT taken: no reads, jumps ignored, restart resumes at START_PC.
    wait_for("t5_bundle20", 1'b1, -1, 40, cyc);
    chk("t5_op20", 32'(ir_op), 32'h20);
    jump_valid = 1'b1; jump_addr = 8'h80;
    @(negedge clk);
    jump_valid = 1'b0;
    wait_for("t5_ir_valid", 1'b1, -1, 40, cyc);
    chk("t5_halt_op", 32'(ir_op), 32'hFF);
    @(negedge clk);
    chk("t5_halted", 32'(halted), 32'd1);
    chk("t5_irp", 32'(irp), 32'h84);
    jump_valid = 1'b1; jump_addr = 8'h50;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      jump_valid = 1'b0;
      chk("t5_no_rd", 32'(mem_rd_en), 32'd0);
      chk("t5_still_halted", 32'(halted), 32'd1);
      chk("t5_irp_kept", 32'(irp), 32'h84);
    end
    @(posedge clk);
    lat = 3;
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chk("t5_unhalted", 32'(halted), 32'd0);
    chk("t5_restart_irp", 32'(irp), 32'(START));
    chk("t5_restart_rd_en", 32'(mem_rd_en), 32'd1);
    chk("t5_restart_addr", 32'(mem_addr), 32'(START));

    // Asynchronous reset while the F_P0 read is outstanding.
    wait_for("t6_p0_rd", 1'b0, 1, 20, cyc);
    #2;
    rst_n = 1'b0;
    cash_init_load_finished = 1'b0;
    #1;
    chk("t6_async_rd_en", 32'(mem_rd_en), 32'd0);
    chk("t6_async_addr", 32'(mem_addr), 32'd0);
    chk("t6_async_op", 32'(ir_op), 32'd0);
    chk("t6_async_valid", 32'(ir_valid), 32'd0);
    chk("t6_async_irp", 32'(irp), 32'(START));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t6_idle_no_rd", 32'(mem_rd_en), 32'd0);
      chk("t6_idle_valid", 32'(ir_valid), 32'd0);
      chk("t6_late_ignored", {ir_op, ir_p0, ir_p1, ir_p2}, 32'd0);
    end
    cash_init_load_finished = 1'b1;
    wait_for("t6_rd", 1'b0, -1, 10, cyc);
    chk("t6_rd_addr", 32'(mem_addr), 32'(START));
    wait_for("t6_ir_valid", 1'b1, -1, 40, cyc);
    chk("t6_bundle", {ir_op, ir_p0, ir_p1, ir_p2}, 32'hCCDD0304);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
